// File: rtl/neuron_mem_host_port.sv
// Host-side initiator for the neuron array's external memory port.
// One command in flight: valid/ready command in, single response out, with starvation timeout.
module neuron_mem_host_port #(
    parameter int unsigned NEURON_NUMBER = 256,
    parameter int unsigned NEUR_WIDTH    = 13,
    parameter int unsigned TIMEOUT       = 1024,
    localparam int unsigned AW           = $clog2(NEURON_NUMBER)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [AW-1:0]         cmd_addr,
    input  logic [NEUR_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [NEUR_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  ext_req,
    input  logic                  ext_ack,
    output logic                  ext_we,
    output logic                  ext_re,
    output logic [AW-1:0]         ext_neur_addr,
    output logic [NEUR_WIDTH-1:0] ext_neur_data_in,
    input  logic [NEUR_WIDTH-1:0] ext_neur_data_out,
    output logic [7:0]            timeout_cnt
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RDCAP = 2'd2,
        RSP   = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic                  we_q, we_nxt;
    logic [AW-1:0]         addr_q, addr_nxt;
    logic [NEUR_WIDTH-1:0] wdata_q, wdata_nxt;
    logic [CW-1:0]         wait_cnt, wait_cnt_nxt;
    logic [NEUR_WIDTH-1:0] rdata_nxt;
    logic                  err_nxt;
    logic [7:0]            timeout_cnt_nxt;
    logic                  addr_oob_c;

    assign addr_oob_c = 32'(cmd_addr) >= 32'(NEURON_NUMBER);

    // Handshake and memory-port strobes decode straight from the state register.
    assign cmd_ready        = (state == IDLE);
    assign rsp_valid        = (state == RSP);
    assign ext_req          = (state == REQ);
    assign ext_we           = ext_req & we_q;
    assign ext_re           = ext_req & ~we_q;
    assign ext_neur_addr    = addr_q;
    assign ext_neur_data_in = wdata_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            timeout_cnt <= 8'd0;
        end else begin
            state       <= state_nxt;
            we_q        <= we_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            wait_cnt    <= wait_cnt_nxt;
            rsp_rdata   <= rdata_nxt;
            rsp_err     <= err_nxt;
            timeout_cnt <= timeout_cnt_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt       = state;
        we_nxt          = we_q;
        addr_nxt        = addr_q;
        wdata_nxt       = wdata_q;
        wait_cnt_nxt    = wait_cnt;
        rdata_nxt       = rsp_rdata;
        err_nxt         = rsp_err;
        timeout_cnt_nxt = timeout_cnt;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    we_nxt    = cmd_we;
                    addr_nxt  = cmd_addr;
                    wdata_nxt = cmd_wdata;
                    if (addr_oob_c) begin
                        state_nxt = RSP;
                        err_nxt   = 1'b1;
                        rdata_nxt = '0;
                    end else begin
                        state_nxt    = REQ;
                        wait_cnt_nxt = '0;
                    end
                end
            end
            REQ: begin
                // A grant on the final wait cycle still wins over the timeout.
                if (ext_ack) begin
                    if (we_q) begin
                        state_nxt = RSP;
                        err_nxt   = 1'b0;
                        rdata_nxt = '0;
                    end else begin
                        state_nxt = RDCAP;
                    end
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    state_nxt = RSP;
                    err_nxt   = 1'b1;
                    rdata_nxt = '0;
                    if (timeout_cnt != 8'hFF) begin
                        timeout_cnt_nxt = timeout_cnt + 8'd1;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
                end
            end
            RDCAP: begin
                // Memory registered the word at the end of the ack cycle.
                state_nxt = RSP;
                rdata_nxt = ext_neur_data_out;
                err_nxt   = 1'b0;
            end
            RSP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neuron_mem_host_port.sv
// Directed bench for neuron_mem_host_port with a registered neuron-memory model and busy arbitration.
module tb_neuron_mem_host_port;

    localparam int unsigned NN = 200;
    localparam int unsigned NW = 13;
    localparam int unsigned TO = 24;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [NW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [NW-1:0] rsp_rdata;
    logic          ext_req, ext_ack, ext_we, ext_re;
    logic [AW-1:0] ext_neur_addr;
    logic [NW-1:0] ext_neur_data_in;
    logic [NW-1:0] ext_neur_data_out;
    logic [7:0]    timeout_cnt;
    logic          module_busy;

    logic [NW-1:0] mem [NN];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [NW-1:0] wdata;
        int            busy;
        int            hold;
        int            exp_lat;
        int            exp_req;
        logic [NW-1:0] exp_rdata;
        logic          exp_err;
        logic [7:0]    exp_tocnt;
    } vec_t;

    vec_t vecs[11];

    neuron_mem_host_port #(
        .NEURON_NUMBER(NN),
        .NEUR_WIDTH   (NW),
        .TIMEOUT      (TO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_we           (cmd_we),
        .cmd_addr         (cmd_addr),
        .cmd_wdata        (cmd_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .rsp_err          (rsp_err),
        .ext_req          (ext_req),
        .ext_ack          (ext_ack),
        .ext_we           (ext_we),
        .ext_re           (ext_re),
        .ext_neur_addr    (ext_neur_addr),
        .ext_neur_data_in (ext_neur_data_in),
        .ext_neur_data_out(ext_neur_data_out),
        .timeout_cnt      (timeout_cnt)
    );

    always #5 clk = ~clk;

    // Neuron module side: grant when not busy, registered read data
    assign ext_ack = ext_req & ~module_busy;

    always @(posedge clk) begin
        if (ext_ack && ext_we) mem[ext_neur_addr] <= ext_neur_data_in;
        if (ext_ack && ext_re) ext_neur_data_out <= mem[ext_neur_addr];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Issue one command at a negedge, track the port, then consume the response.
    task automatic run_cmd(input vec_t v, input string tag);
        int            cyc;
        int            reqs;
        int            busy_left;
        logic          bad_addr, bad_dir, bad_data, unstable;
        logic [NW-1:0] rd;
        logic          er;
        busy_left = v.busy;
        reqs      = 0;
        bad_addr  = 1'b0;
        bad_dir   = 1'b0;
        bad_data  = 1'b0;
        unstable  = 1'b0;
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        check({tag, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cyc       = 1;
        while (!rsp_valid && cyc < 200) begin
            if (ext_req) begin
                reqs++;
                if (ext_neur_addr !== v.addr) bad_addr = 1'b1;
                if (ext_we !== v.we || ext_re !== !v.we) bad_dir = 1'b1;
                if (v.we && ext_neur_data_in !== v.wdata) bad_data = 1'b1;
                module_busy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
            end else begin
                module_busy = 1'b0;
                if (ext_we || ext_re) bad_dir = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        module_busy = 1'b0;
        check({tag, " rsp_latency"}, 32'(cyc), 32'(v.exp_lat));
        check({tag, " ext_req_cycles"}, 32'(reqs), 32'(v.exp_req));
        check({tag, " addr_stable"}, 32'(bad_addr), 32'd0);
        check({tag, " we_re_strobes"}, 32'(bad_dir), 32'd0);
        check({tag, " wdata_out"}, 32'(bad_data), 32'd0);
        check({tag, " ext_req_in_rsp"}, 32'(ext_req), 32'd0);
        check({tag, " cmd_ready_in_rsp"}, 32'(cmd_ready), 32'd0);
        check({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(v.exp_rdata));
        check({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
        check({tag, " timeout_cnt"}, 32'(timeout_cnt), 32'(v.exp_tocnt));
        rd = rsp_rdata;
        er = rsp_err;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || cmd_ready) unstable = 1'b1;
        end
        if (v.hold > 0) check({tag, " rsp_hold_stable"}, 32'(unstable), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
        check({tag, " cmd_ready_after_hs"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic bad;
        vec_t v;
        //          we    addr    wdata     busy hold lat req rdata     err   tocnt
        vecs[0]  = '{1'b1, 8'd10,  13'h1A5,  0,    0,   2,  1,  13'h0,    1'b0, 8'd0};
        vecs[1]  = '{1'b0, 8'd10,  13'h0,    0,    5,   3,  1,  13'h1A5,  1'b0, 8'd0};
        vecs[2]  = '{1'b0, 8'd10,  13'h0,    20,   0,   23, 21, 13'h1A5,  1'b0, 8'd0};
        vecs[3]  = '{1'b1, 8'd199, 13'h1FFF, 3,    0,   5,  4,  13'h0,    1'b0, 8'd0};
        vecs[4]  = '{1'b0, 8'd199, 13'h0,    0,    0,   3,  1,  13'h1FFF, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 8'd200, 13'h0,    0,    0,   1,  0,  13'h0,    1'b1, 8'd0};
        vecs[6]  = '{1'b1, 8'd210, 13'h555,  0,    2,   1,  0,  13'h0,    1'b1, 8'd0};
        vecs[7]  = '{1'b1, 8'd0,   13'h0AA,  23,   0,   25, 24, 13'h0,    1'b0, 8'd0};
        vecs[8]  = '{1'b0, 8'd0,   13'h0,    0,    0,   3,  1,  13'h0AA,  1'b0, 8'd0};
        vecs[9]  = '{1'b0, 8'd10,  13'h0,    1000, 0,   25, 24, 13'h0,    1'b1, 8'd1};
        vecs[10] = '{1'b0, 8'd10,  13'h0,    0,    0,   3,  1,  13'h1A5,  1'b0, 8'd1};

        for (int i = 0; i < int'(NN); i++) mem[i] = '0;
        ext_neur_data_out = '0;
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_we      = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        rsp_ready   = 1'b0;
        module_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ext_req", 32'(ext_req), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i], $sformatf("v%0d", i));
            if (i == 0) check("v0 mem10", 32'(mem[10]), 32'h1A5);
            if (i == 3) check("v3 mem199", 32'(mem[199]), 32'h1FFF);
        end

        // Reset while a starved read sits in REQ: no response may follow.
        cmd_valid   = 1'b1;
        cmd_we      = 1'b0;
        cmd_addr    = 8'd10;
        module_busy = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        repeat (2) @(negedge clk);
        check("rst_mid ext_req_before", 32'(ext_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid ext_req_async", 32'(ext_req), 32'd0);
        check("rst_mid ext_re_async", 32'(ext_re), 32'd0);
        check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid timeout_cnt", 32'(timeout_cnt), 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        module_busy = 1'b0;
        bad         = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || ext_req || !cmd_ready) bad = 1'b1;
        end
        check("rst_mid quiet_after", 32'(bad), 32'd0);

        v = vecs[10];
        v.exp_tocnt = 8'd0;
        run_cmd(v, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
